// File: rtl/seq_match_logger_if.sv
// Timestamp stream between the match logger (master) and its consumer (slave).
//   ts_data  : timestamp at the FIFO head, meaningful only while ts_valid=1
//   ts_valid : FIFO holds at least one entry
//   ts_ready : consumer takes the head entry this cycle
interface seq_match_logger_if #(
  parameter int TS_W = 16
);
  logic [TS_W-1:0] ts_data;
  logic            ts_valid;
  logic            ts_ready;

  modport master (output ts_data, output ts_valid, input ts_ready);
  modport slave  (input ts_data, input ts_valid, output ts_ready);
endinterface

// File: rtl/seq_match_logger.sv
// Sequence match logger: counts serial bits, timestamps each cycle the detector
// flags a match, and queues those timestamps in a first-word-fall-through FIFO
// drained over a valid/ready stream. Saturating match/drop counters and a
// sticky overflow flag report status.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bit_valid_i    : a serial bit was presented this cycle (advances timestamp)
//   detected_i     : match event this cycle (pushes current timestamp)
//   clear_i        : synchronous soft clear, overrides all other activity
//   ts_if          : master side of the timestamp stream
//   fifo_level_o   : entries held, 0..DEPTH
//   match_count_o  : match events seen, saturating
//   drop_count_o   : events lost to a full FIFO, saturating
//   overflow_o     : sticky, at least one drop since reset/clear
module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_valid_i,
  input  logic                     detected_i,
  input  logic                     clear_i,
  seq_match_logger_if.master       ts_if,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic [CNT_W-1:0]         match_count_o,
  output logic [CNT_W-1:0]         drop_count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic full, empty, pop, push, drop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && ts_if.ts_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = detected_i && (!full || pop);
  assign drop  = detected_i && full && !pop;

  always_comb begin
    ts_d     = ts_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    match_d  = match_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (clear_i) begin
      ts_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      match_d  = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (bit_valid_i) ts_d = ts_q + TS_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (detected_i && (match_q != '1)) match_d = match_q + CNT_W'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      match_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      match_q  <= match_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; contents are only visible through ts_valid.
  always_ff @(posedge clk) begin
    if (push && !clear_i) mem_q[wr_ptr_q] <= ts_q;
  end

  assign ts_if.ts_data  = mem_q[rd_ptr_q];
  assign ts_if.ts_valid = !empty;
  assign fifo_level_o   = level_q;
  assign match_count_o  = match_q;
  assign drop_count_o   = drop_q;
  assign overflow_o     = ovf_q;
endmodule
